// File: rtl/issue_ctrl_if.sv
// Decode, execution-unit handshake and writeback signals around the issue controller.
// The controller attaches through the slave modport; its environment drives the master side.
interface issue_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   dec_valid_i;
  logic                   dec_ready_o;
  logic                   dec_req_ra_i;
  logic                   dec_req_rb_i;
  logic [4:0]             dec_raddr_a_i;
  logic [4:0]             dec_raddr_b_i;
  logic                   dec_we_i;
  logic [4:0]             dec_waddr_i;
  logic [1:0]             dec_unit_i;
  logic                   issue_o;
  logic                   alu_req_o;
  logic                   alu_ack_i;
  logic                   pc_alu_req_o;
  logic                   pc_alu_ack_i;
  logic                   lsu_req_o;
  logic                   lsu_ack_i;
  logic                   pc_done_i;
  logic                   wb_valid_i;
  logic [4:0]             wb_waddr_i;
  logic [31:0]            busy_o;
  logic                   stall_o;
  logic                   illegal_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;

  modport master (
    output dec_valid_i, dec_req_ra_i, dec_req_rb_i, dec_raddr_a_i, dec_raddr_b_i,
           dec_we_i, dec_waddr_i, dec_unit_i, alu_ack_i, pc_alu_ack_i, lsu_ack_i,
           pc_done_i, wb_valid_i, wb_waddr_i,
    input  dec_ready_o, issue_o, alu_req_o, pc_alu_req_o, lsu_req_o, busy_o,
           stall_o, illegal_o, stall_cnt_o
  );

  modport slave (
    input  dec_valid_i, dec_req_ra_i, dec_req_rb_i, dec_raddr_a_i, dec_raddr_b_i,
           dec_we_i, dec_waddr_i, dec_unit_i, alu_ack_i, pc_alu_ack_i, lsu_ack_i,
           pc_done_i, wb_valid_i, wb_waddr_i,
    output dec_ready_o, issue_o, alu_req_o, pc_alu_req_o, lsu_req_o, busy_o,
           stall_o, illegal_o, stall_cnt_o
  );
endinterface

// File: rtl/issue_ctrl.sv
// Issue-stage sequencer: RAW/WAW check against a 32-entry busy scoreboard, then
// dispatch to ALU, PC_ALU or LSU, holding after PC_ALU until the branch resolves.
module issue_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input logic         clk_i,
  input logic         rst_ni,
  issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_DISPATCH = 2'd2,
    ST_BR_WAIT  = 2'd3
  } state_t;

  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_PC  = 2'd1;
  localparam logic [1:0] UNIT_LSU = 2'd2;
  localparam logic [1:0] UNIT_ILL = 2'd3;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   req_ra_r;
  logic                   req_rb_r;
  logic                   we_r;
  logic [4:0]             raddr_a_r;
  logic [4:0]             raddr_b_r;
  logic [4:0]             waddr_r;
  logic [1:0]             unit_r;
  logic [31:0]            busy_r;
  logic [31:0]            busy_eff_s;
  logic [31:0]            busy_next_s;
  logic [31:0]            wb_clr_s;
  logic [31:0]            issue_set_s;
  logic [STALL_CNT_W-1:0] stall_cnt_r;
  logic                   alu_req_r;
  logic                   pc_alu_req_r;
  logic                   lsu_req_r;
  logic                   illegal_r;
  logic                   accept_s;
  logic                   illegal_s;
  logic                   hazard_s;
  logic                   issue_s;
  logic                   stall_s;
  logic                   transfer_s;

  // x0 maps to an all-zero vector so it can never become busy or cause a hazard
  function automatic logic [31:0] reg_onehot(input logic [4:0] addr);
    logic [31:0] vec;
    vec = 32'd0;
    if (addr != 5'd0) begin
      vec[addr] = 1'b1;
    end else begin
      vec = 32'd0;
    end
    return vec;
  endfunction

  assign accept_s   = (state_r == ST_IDLE) && bus.dec_valid_i && (bus.dec_unit_i != UNIT_ILL);
  assign illegal_s  = (state_r == ST_IDLE) && bus.dec_valid_i && (bus.dec_unit_i == UNIT_ILL);
  assign transfer_s = (alu_req_r && bus.alu_ack_i) || (pc_alu_req_r && bus.pc_alu_ack_i) ||
                      (lsu_req_r && bus.lsu_ack_i);

  // Writeback bypass, hazard detection and scoreboard next value (a set beats a clear)
  always_comb begin
    wb_clr_s = 32'd0;
    if (bus.wb_valid_i) begin
      wb_clr_s = reg_onehot(bus.wb_waddr_i);
    end else begin
      wb_clr_s = 32'd0;
    end
    busy_eff_s = busy_r & ~wb_clr_s;
    hazard_s   = (req_ra_r && busy_eff_s[raddr_a_r]) || (req_rb_r && busy_eff_s[raddr_b_r]) ||
                 (we_r && busy_eff_s[waddr_r]);
    issue_s    = (state_r == ST_CHECK) && !hazard_s;
    stall_s    = (state_r == ST_CHECK) && hazard_s;
    issue_set_s = 32'd0;
    if (issue_s && we_r) begin
      issue_set_s = reg_onehot(waddr_r);
    end else begin
      issue_set_s = 32'd0;
    end
    busy_next_s = busy_eff_s | issue_set_s;
  end

  // Next-state selection
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_CHECK;
        else          state_next_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (hazard_s) state_next_s = ST_CHECK;
        else          state_next_s = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (!transfer_s)          state_next_s = ST_DISPATCH;
        else if (unit_r == UNIT_PC) state_next_s = ST_BR_WAIT;
        else                      state_next_s = ST_IDLE;
      end
      ST_BR_WAIT: begin
        if (bus.pc_done_i) state_next_s = ST_IDLE;
        else               state_next_s = ST_BR_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, scoreboard, stall counter and registered unit requests
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      busy_r       <= 32'd0;
      stall_cnt_r  <= {STALL_CNT_W{1'b0}};
      alu_req_r    <= 1'b0;
      pc_alu_req_r <= 1'b0;
      lsu_req_r    <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      busy_r       <= busy_next_s;
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      alu_req_r    <= (state_next_s == ST_DISPATCH) && (unit_r == UNIT_ALU);
      pc_alu_req_r <= (state_next_s == ST_DISPATCH) && (unit_r == UNIT_PC);
      lsu_req_r    <= (state_next_s == ST_DISPATCH) && (unit_r == UNIT_LSU);
      illegal_r    <= illegal_s;
    end
  end

  // Instruction capture on acceptance
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_ra_r  <= 1'b0;
      req_rb_r  <= 1'b0;
      we_r      <= 1'b0;
      raddr_a_r <= 5'd0;
      raddr_b_r <= 5'd0;
      waddr_r   <= 5'd0;
      unit_r    <= UNIT_ALU;
    end else if (accept_s) begin
      req_ra_r  <= bus.dec_req_ra_i;
      req_rb_r  <= bus.dec_req_rb_i;
      we_r      <= bus.dec_we_i;
      raddr_a_r <= bus.dec_raddr_a_i;
      raddr_b_r <= bus.dec_raddr_b_i;
      waddr_r   <= bus.dec_waddr_i;
      unit_r    <= bus.dec_unit_i;
    end
  end

  assign bus.dec_ready_o  = (state_r == ST_IDLE) && rst_ni;
  assign bus.issue_o      = issue_s;
  assign bus.stall_o      = stall_s;
  assign bus.alu_req_o    = alu_req_r;
  assign bus.pc_alu_req_o = pc_alu_req_r;
  assign bus.lsu_req_o    = lsu_req_r;
  assign bus.illegal_o    = illegal_r;
  assign bus.busy_o       = busy_r;
  assign bus.stall_cnt_o  = stall_cnt_r;

endmodule
